// File: rtl/bool_truth_scanner_pkg.sv
// Shared types and constants for the 4-input truth-table scanner.
package bool_scan_pkg;

    localparam int VEC_W    = 4;
    localparam int N_VEC    = 16;
    localparam int SETTLE_W = 8;
    localparam int FAIL_W   = 5;

    // Reference function (a&b)|(c&d), bit i = y for vector i.
    localparam logic [N_VEC-1:0] TT_AB_OR_CD = 16'hF888;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/bool_truth_scanner_if.sv
// Stimulus/response bundle between the scanner and whoever starts it and supplies y.
interface bool_truth_scanner_if;
    import bool_scan_pkg::*;

    // start is a request sampled only while the scanner is idle; done is a
    // one-cycle completion pulse and results stay valid until the next accepted start.
    logic                 start;
    logic [VEC_W-1:0]     vec_out;
    logic                 y_in;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [N_VEC-1:0]     table_out;
    logic [FAIL_W-1:0]    fail_count;
    logic                 first_fail_valid;
    logic [VEC_W-1:0]     first_fail_idx;
    logic                 xz_seen;
    state_t               state_dbg;

    modport master (
        output start, y_in,
        input  vec_out, busy, done, pass, table_out, fail_count,
               first_fail_valid, first_fail_idx, xz_seen, state_dbg
    );

    modport slave (
        input  start, y_in,
        output vec_out, busy, done, pass, table_out, fail_count,
               first_fail_valid, first_fail_idx, xz_seen, state_dbg
    );

endinterface

// File: rtl/bool_truth_scanner.sv
// Walks all 16 {a,b,c,d} vectors, samples y after a settle window, and grades
// the captured truth table against an expected mask.
module bool_truth_scanner
    import bool_scan_pkg::*;
#(
    parameter int unsigned      SETTLE_CYCLES = 2,
    parameter logic [N_VEC-1:0] EXPECTED      = TT_AB_OR_CD
) (
    input logic                 clk,
    input logic                 rst_n,
    bool_truth_scanner_if.slave bus
);

    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [VEC_W-1:0]    IDX_LAST    = VEC_W'(N_VEC - 1);

    state_t              state_q;
    logic [VEC_W-1:0]    idx_q;
    logic [SETTLE_W-1:0] settle_q;
    logic [VEC_W-1:0]    vec_q;
    logic                busy_q;
    logic                done_q;
    logic                pass_q;
    logic [N_VEC-1:0]    table_q;
    logic [FAIL_W-1:0]   fail_q;
    logic                ffv_q;
    logic [VEC_W-1:0]    ffi_q;
    logic                xz_q;

    logic                y_one;
    logic                y_xz;
    logic                miss;
    logic [FAIL_W-1:0]   fail_d;
    logic                xz_d;

    // Only a clean 1 counts as 1; anything not cleanly 0 or 1 is flagged.
    always_comb begin
        y_one  = (bus.y_in === 1'b1);
        y_xz   = !((bus.y_in === 1'b0) || y_one);
        miss   = (y_one != EXPECTED[idx_q]);
        fail_d = miss ? fail_q + FAIL_W'(1) : fail_q;
        xz_d   = xz_q | y_xz;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            settle_q <= '0;
            vec_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            table_q  <= '0;
            fail_q   <= '0;
            ffv_q    <= 1'b0;
            ffi_q    <= '0;
            xz_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    vec_q <= '0;
                    if (bus.start) begin
                        state_q  <= DRIVE;
                        idx_q    <= '0;
                        settle_q <= '0;
                        busy_q   <= 1'b1;
                        pass_q   <= 1'b0;
                        table_q  <= '0;
                        fail_q   <= '0;
                        ffv_q    <= 1'b0;
                        ffi_q    <= '0;
                        xz_q     <= 1'b0;
                    end
                end
                DRIVE: begin
                    settle_q <= settle_q + SETTLE_W'(1);
                    if (settle_q == SETTLE_LAST) begin
                        state_q <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    table_q[idx_q] <= y_one;
                    fail_q         <= fail_d;
                    xz_q           <= xz_d;
                    if (miss && !ffv_q) begin
                        ffv_q <= 1'b1;
                        ffi_q <= idx_q;
                    end
                    if (idx_q == IDX_LAST) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        pass_q  <= (fail_d == '0) && !xz_d;
                    end else begin
                        state_q  <= DRIVE;
                        idx_q    <= idx_q + VEC_W'(1);
                        vec_q    <= idx_q + VEC_W'(1);
                        settle_q <= '0;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    vec_q   <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.vec_out          = vec_q;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.pass             = pass_q;
    assign bus.table_out        = table_q;
    assign bus.fail_count       = fail_q;
    assign bus.first_fail_valid = ffv_q;
    assign bus.first_fail_idx   = ffi_q;
    assign bus.xz_seen          = xz_q;
    assign bus.state_dbg        = state_q;

endmodule

// File: tb/tb_bool_truth_scanner.sv
// Scoreboard bench: two scanners (settle 2 and settle 1) driven by table-defined
// devices, graded against a truth-table model of the expected grading.
module tb_bool_truth_scanner;
    import bool_scan_pkg::*;

    typedef struct packed {
        logic [15:0] tbl;
        logic [4:0]  fails;
        logic        ffv;
        logic [3:0]  ffi;
        logic        xz;
        logic        pass;
    } exp_t;

    localparam int S0 = 2;
    localparam int S1 = 1;

    // clock / reset
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bool_truth_scanner_if bus0 ();
    bool_truth_scanner_if bus1 ();

    bool_truth_scanner #(.SETTLE_CYCLES(S0), .EXPECTED(TT_AB_OR_CD)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
    );
    bool_truth_scanner #(.SETTLE_CYCLES(S1), .EXPECTED(TT_AB_OR_CD)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    // device under evaluation: one response per vector, possibly high-impedance
    logic dev_tbl0 [16];
    logic dev_tbl1 [16];
    always_comb bus0.y_in = dev_tbl0[bus0.vec_out];
    always_comb bus1.y_in = dev_tbl1[bus1.vec_out];

    // scoreboard state
    exp_t exp_q0[$];
    exp_t exp_q1[$];
    bit   active[2];
    int   acc[2];
    int   idle_from[2];
    bit   hold[2];
    exp_t last_exp[2];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input int i, input string name, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL inst%0d %s: got %h expected %h (cycle %0d)", i, name, act, want, cyc);
    endtask

    task automatic fail_now(input int i, input string name);
        n_checks++;
        $display("FAIL inst%0d %s: bound expired (cycle %0d)", i, name, cyc);
    endtask

    function automatic int settle_of(input int i);
        return (i == 0) ? S0 : S1;
    endfunction

    function automatic int qsize(input int i);
        return (i == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    task automatic push_exp(input int i, input exp_t e);
        if (i == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
    endtask

    task automatic pop_exp(input int i, output exp_t e, output bit ok);
        ok = (qsize(i) != 0);
        e  = '0;
        if (ok) e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
    endtask

    // Reference grading: table = vectors whose response was a clean 1.
    function automatic exp_t grade(input logic [15:0] is_one, input logic [15:0] unknown,
                                   input logic [15:0] want);
        exp_t e;
        e     = '0;
        e.tbl = is_one;
        for (int v = 0; v < 16; v++) begin
            if (is_one[v] != want[v]) begin
                e.fails = e.fails + 5'd1;
                if (!e.ffv) begin
                    e.ffv = 1'b1;
                    e.ffi = 4'(v);
                end
            end
        end
        e.xz   = |unknown;
        e.pass = (e.fails == 5'd0) && !e.xz;
        return e;
    endfunction

    function automatic exp_t predict(input int i);
        logic [15:0] one;
        logic [15:0] unk;
        logic        y;
        for (int v = 0; v < 16; v++) begin
            y      = (i == 0) ? dev_tbl0[v] : dev_tbl1[v];
            one[v] = (y === 1'b1);
            unk[v] = !((y === 1'b0) || (y === 1'b1));
        end
        return grade(one, unk, TT_AB_OR_CD);
    endfunction

    // driver tasks
    task automatic set_start(input int i, input logic v);
        if (i == 0) bus0.start = v;
        else        bus1.start = v;
    endtask

    task automatic load_dev(input int i, input logic [15:0] func, input logic [15:0] zmask);
        for (int v = 0; v < 16; v++) begin
            if (i == 0) dev_tbl0[v] = zmask[v] ? 1'bz : func[v];
            else        dev_tbl1[v] = zmask[v] ? 1'bz : func[v];
        end
    endtask

    task automatic wait_idle(input int i);
        int n;
        n = 0;
        @(negedge clk);
        while ((active[i] || cyc < idle_from[i]) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) fail_now(i, "wait_idle");
    endtask

    task automatic run_scan(input int i, input logic [15:0] func, input logic [15:0] zmask);
        wait_idle(i);
        load_dev(i, func, zmask);
        push_exp(i, predict(i));
        active[i] = 1'b1;
        acc[i]    = cyc + 1;
        set_start(i, 1'b1);
        @(negedge clk);
        set_start(i, 1'b0);
    endtask

    // start held high across two scans; released once both results are graded
    task automatic run_held(input int i, input logic [15:0] func);
        int n;
        wait_idle(i);
        load_dev(i, func, 16'h0000);
        push_exp(i, predict(i));
        push_exp(i, predict(i));
        hold[i]   = 1'b1;
        active[i] = 1'b1;
        acc[i]    = cyc + 1;
        set_start(i, 1'b1);
        n = 0;
        while (qsize(i) != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) fail_now(i, "held_scans");
        set_start(i, 1'b0);
        hold[i] = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        exp_q0.delete();
        exp_q1.delete();
        for (int i = 0; i < 2; i++) begin
            active[i]    = 1'b0;
            hold[i]      = 1'b0;
            idle_from[i] = 0;
            last_exp[i]  = '0;
        end
        repeat (cycles) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // monitor
    task automatic mon(input int i, input logic busy, input logic done, input logic pass,
                       input logic [15:0] tbl, input logic [4:0] fails, input logic ffv,
                       input logic [3:0] ffi, input logic xz, input logic [3:0] vec);
        int   k;
        int   per;
        exp_t e;
        bit   ok;
        per = settle_of(i) + 1;
        if (rst_n !== 1'b1) begin
            check(i, "reset_outputs", 64'({busy, done, pass, tbl, fails, ffv, ffi, xz, vec}), 64'd0);
        end else if (active[i] && cyc >= acc[i]) begin
            k = cyc - acc[i];
            if (k < 16 * per) begin
                check(i, "scan_busy_done_vec", 64'({busy, done, vec}), 64'({1'b1, 1'b0, 4'(k / per)}));
            end else begin
                check(i, "done_at_latency", 64'({busy, done, vec}), 64'({1'b1, 1'b1, 4'hF}));
                pop_exp(i, e, ok);
                if (!ok) begin
                    fail_now(i, "scoreboard_empty");
                end else begin
                    check(i, "table_out", 64'(tbl), 64'(e.tbl));
                    check(i, "fail_count", 64'(fails), 64'(e.fails));
                    check(i, "first_fail", 64'({ffv, ffi}), 64'({e.ffv, e.ffi}));
                    check(i, "xz_seen", 64'(xz), 64'(e.xz));
                    check(i, "pass", 64'(pass), 64'(e.pass));
                    last_exp[i] = e;
                end
                active[i]    = 1'b0;
                idle_from[i] = cyc + 1;
                if (hold[i] && qsize(i) != 0) begin
                    active[i] = 1'b1;
                    acc[i]    = cyc + 2;
                end
            end
        end else begin
            check(i, "idle_busy_done_vec", 64'({busy, done, vec}), 64'd0);
            check(i, "idle_result_hold", 64'({tbl, fails, ffv, ffi, xz, pass}), 64'(last_exp[i]));
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            mon(0, bus0.busy, bus0.done, bus0.pass, bus0.table_out, bus0.fail_count,
                bus0.first_fail_valid, bus0.first_fail_idx, bus0.xz_seen, bus0.vec_out);
            mon(1, bus1.busy, bus1.done, bus1.pass, bus1.table_out, bus1.fail_count,
                bus1.first_fail_valid, bus1.first_fail_idx, bus1.xz_seen, bus1.vec_out);
        end
    end

    // stimulus
    initial begin
        logic [15:0] zm;
        bus0.start = 1'b0;
        bus1.start = 1'b0;
        load_dev(0, TT_AB_OR_CD, 16'h0000);
        load_dev(1, TT_AB_OR_CD, 16'h0000);
        do_reset(3);

        run_scan(0, TT_AB_OR_CD, 16'h0000);   // good model
        run_scan(0, 16'h0000, 16'h0000);      // stuck at 0
        run_scan(0, TT_AB_OR_CD, 16'h0020);   // high-impedance at vector 5

        repeat (4) begin
            zm = ($urandom_range(0, 2) == 0) ? (16'h0001 << $urandom_range(0, 15)) : 16'h0000;
            run_scan(0, 16'($urandom), zm);
        end

        // extra start at vector 7 is ignored, then reset lands in vector 7
        run_scan(0, TT_AB_OR_CD, 16'h0000);
        repeat (7 * (S0 + 1)) @(negedge clk);
        bus0.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        do_reset(3);
        run_scan(0, TT_AB_OR_CD, 16'h0000);   // full latency after reset

        run_held(1, TT_AB_OR_CD);
        repeat (3) run_scan(1, 16'($urandom), 16'h0000);
        run_scan(1, 16'h0000, 16'h0000);

        wait_idle(0);
        wait_idle(1);
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
